// File: rtl/fpu_pkg.sv
// Shared single-precision constants and the multicycle divider state encoding.
// No logic here: parameters and types only, no latency.
// No flow control.
package fpu_pkg;

   localparam int FLOAT_W = 32;

   localparam logic [7:0]         EXP_ZERO = 8'h00;
   localparam logic [7:0]         EXP_INF  = 8'hFF;
   localparam logic [7:0]         BIAS     = 8'h7F;
   localparam logic [FLOAT_W-1:0] QNAN     = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } fdiv_state_e;

endpackage

// File: rtl/fdiv.sv
// Combinational IEEE-754 single divide, round-to-nearest-even, denormals flushed to zero.
// Latency: purely combinational, meant to be given several cycles to settle by its caller.
// No flow control; the output follows the inputs.
module fdiv
   import fpu_pkg::*;
(
   input  logic [FLOAT_W-1:0] a_i,
   input  logic [FLOAT_W-1:0] b_i,
   output logic [FLOAT_W-1:0] q_o
);

   logic               sign;
   logic [7:0]         ea, eb;
   logic [22:0]        fa, fb;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [23:0]        ma, mb;
   logic [48:0]        num, den;
   logic [25:0]        quo;
   logic [23:0]        rem;
   logic [23:0]        mant;
   logic               guard, sticky, rnd_up;
   logic [24:0]        mant_r;
   logic [22:0]        frac;
   logic signed [9:0]  exp_n;

   assign sign   = a_i[31] ^ b_i[31];
   assign ea     = a_i[30:23];
   assign eb     = b_i[30:23];
   assign fa     = a_i[22:0];
   assign fb     = b_i[22:0];
   assign a_nan  = (ea == EXP_INF) && (fa != '0);
   assign b_nan  = (eb == EXP_INF) && (fb != '0);
   assign a_inf  = (ea == EXP_INF) && (fa == '0);
   assign b_inf  = (eb == EXP_INF) && (fb == '0);
   assign a_zero = (ea == EXP_ZERO);
   assign b_zero = (eb == EXP_ZERO);

   // Mantissa ratio scaled so the quotient keeps 24 result bits plus guard and sticky.
   assign ma  = {1'b1, fa};
   assign mb  = {1'b1, fb};
   assign num = {ma, 25'b0};
   assign den = {25'b0, mb};
   assign quo = 26'(num / den);
   assign rem = 24'(num % den);

   // Normalise (ratio is in [0.5, 2)) and round to nearest even.
   always_comb begin
      mant   = quo[25] ? quo[25:2] : quo[24:1];
      guard  = quo[25] ? quo[1] : quo[0];
      sticky = (quo[25] & quo[0]) | (rem != '0);
      rnd_up = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + {24'b0, rnd_up};
      // A rounding carry leaves mant_r at exactly 2^24, so the shifted fraction is zero.
      frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      exp_n  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed({2'b00, BIAS})
               - (quo[25] ? 10'sd0 : 10'sd1) + (mant_r[24] ? 10'sd1 : 10'sd0);
   end

   // Operand class handling first, then overflow/underflow of the finite result.
   always_comb begin
      q_o = QNAN;
      if (a_nan || b_nan) begin
         q_o = QNAN;
      end else if (a_inf) begin
         q_o = b_inf ? QNAN : {sign, EXP_INF, 23'h0};
      end else if (b_inf) begin
         q_o = {sign, 31'h0};
      end else if (a_zero) begin
         q_o = b_zero ? QNAN : {sign, 31'h0};
      end else if (b_zero) begin
         q_o = {sign, EXP_INF, 23'h0};
      end else if (exp_n > 10'sd254) begin
         q_o = {sign, EXP_INF, 23'h0};
      end else if (exp_n < 10'sd1) begin
         q_o = {sign, 31'h0};
      end else begin
         q_o = {sign, exp_n[7:0], frac};
      end
   end

endmodule

// File: rtl/fdiv_mc.sv
// Multicycle wrapper: latches operands, gives the combinational divider LATENCY cycles, registers rd/dz.
// Latency: out_valid rises exactly LATENCY edges after the accept edge; one op in flight.
// Backpressure: result held while out_ready is low; in_ready low in WAIT and in DONE without out_ready.
module fdiv_mc
   import fpu_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FLOAT_W-1:0] rs1,
   input  logic [FLOAT_W-1:0] rs2,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FLOAT_W-1:0] rd,
   output logic               dz,
   output logic               busy
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_WAIT = ST_WAIT;
   localparam logic [1:0] S_DONE = ST_DONE;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [FLOAT_W-1:0] op_a_q, op_a_d;
   logic [FLOAT_W-1:0] op_b_q, op_b_d;
   logic [FLOAT_W-1:0] rd_q, rd_d;
   logic               dz_q, dz_d;

   logic               accept;
   logic [FLOAT_W-1:0] quo;
   logic               sign_s;
   logic [7:0]         ea_s, eb_s;
   logic [FLOAT_W-1:0] res_rd;
   logic               res_dz;

   // The operand-register -> rd/dz paths through this instance are timed as multicycle = LATENCY.
   fdiv u_fdiv (
      .a_i (op_a_q),
      .b_i (op_b_q),
      .q_o (quo)
   );

   assign in_ready  = rstn && !flush &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign rd        = rd_q;
   assign dz        = dz_q;

   assign sign_s = op_a_q[31] ^ op_b_q[31];
   assign ea_s   = op_a_q[30:23];
   assign eb_s   = op_b_q[30:23];

   // Zero-exponent divisor overrides the divider result and raises dz, decoded from latched operands.
   always_comb begin
      res_rd = quo;
      res_dz = 1'b0;
      if ((eb_s == EXP_ZERO) && (ea_s != EXP_ZERO)) begin
         res_rd = {sign_s, EXP_INF, 23'h0};
         res_dz = 1'b1;
      end else if ((eb_s == EXP_ZERO) && (ea_s == EXP_ZERO)) begin
         res_rd = {sign_s, 31'h0};
         res_dz = 1'b1;
      end
   end

   // Control FSM: accept, count down the settle window, capture, hand off; flush beats everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      rd_d    = rd_q;
      dz_d    = dz_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_a_d  = rs1;
                  op_b_d  = rs2;
                  cnt_d   = CNT_LOAD;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  rd_d    = res_rd;
                  dz_d    = res_dz;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  if (accept) begin
                     op_a_d  = rs1;
                     op_b_d  = rs2;
                     cnt_d   = CNT_LOAD;
                     state_d = S_WAIT;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   // State registers; reset discards any operation in progress.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         rd_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         rd_q    <= rd_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: tb/tb_fdiv_mc.sv
// Self-checking bench for fdiv_mc: scoreboard of expected results, latency and hold checks.
// Latency checked at LATENCY edges from accept; one op in flight.
// Exercises backpressure, back-to-back, flush and asynchronous reset.
module tb_fdiv_mc;

   localparam int LATENCY = 4;
   localparam int NVEC    = 10;

   localparam logic [31:0] VA [NVEC] = '{32'h40C00000, 32'h3F800000, 32'h00000000, 32'h3F800000,
                                         32'hC1100000, 32'h3F800000, 32'h00000000, 32'h40000000,
                                         32'h40E00000, 32'h80000000};
   localparam logic [31:0] VB [NVEC] = '{32'h40000000, 32'h80000000, 32'h00000000, 32'h40400000,
                                         32'h40400000, 32'h40800000, 32'h40A00000, 32'h00000001,
                                         32'h00000000, 32'h00000000};
   localparam logic [31:0] VR [NVEC] = '{32'h40400000, 32'hFF800000, 32'h00000000, 32'h3EAAAAAB,
                                         32'hC0400000, 32'h3E800000, 32'h00000000, 32'h7F800000,
                                         32'h7F800000, 32'h80000000};
   localparam logic        VD [NVEC] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   typedef struct {
      logic [31:0] rd;
      logic        dz;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] rd;
   logic        dz;
   logic        busy;

   exp_t        sb_q[$];
   int          rise_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_out = 0;
   int          n_before;
   logic        ov_prev = 1'b0;
   logic [31:0] exp_rd_cur = '0;
   logic        exp_dz_cur = 1'b0;

   fdiv_mc #(.LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd        (rd),
      .dz        (dz),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Monitor: observe mid-cycle, push on accept, compare and pop on output transfer.
   always @(negedge clk) begin
      if (rstn) begin
         if (out_valid && !ov_prev) begin
            rise_q.push_back(cyc);
            if (sb_q.size() != 0) check_val("latency", 32'(cyc - sb_q[0].acc), 32'(LATENCY));
         end
         if (out_valid) begin
            check_val("out_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               check_val("rd", rd, sb_q[0].rd);
               check_val("dz", {31'b0, dz}, {31'b0, sb_q[0].dz});
               if (out_ready) begin
                  void'(sb_q.pop_front());
                  n_out++;
               end else begin
                  check_val("bp_in_ready", {31'b0, in_ready}, 32'd0);
               end
            end
         end
         if (busy && !out_valid) check_val("wait_in_ready", {31'b0, in_ready}, 32'd0);
         if (in_valid && in_ready) sb_q.push_back('{rd: exp_rd_cur, dz: exp_dz_cur, acc: cyc + 1});
      end
      ov_prev = out_valid;
   end

   // Offer one pair and hold it until accepted; returns just after the accept edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ed);
      logic ok;
      ok         = 1'b0;
      rs1        = a;
      rs2        = b;
      exp_rd_cur = er;
      exp_dz_cur = ed;
      in_valid   = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check_val("accept", {31'b0, ok}, 32'd1);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_ov();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check_val("ov_seen", {31'b0, out_valid}, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !out_valid) break;
      end
      check_val("drain", 32'(sb_q.size()), 32'd0);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      // Reset state
      #1 rstn = 1'b0;
      #3;
      check_val("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_val("rst_busy", {31'b0, busy}, 32'd0);
      check_val("rst_rd", rd, 32'd0);
      check_val("rst_dz", {31'b0, dz}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      check_val("rel_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #2;

      // 6.0 / 2.0 from idle
      send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      drain();

      // Vector table, offered back-to-back
      for (int i = 0; i < NVEC; i++) send(VA[i], VB[i], VR[i], VD[i]);
      drain();

      // Backpressure: hold result for several cycles, then one transfer
      out_ready = 1'b0;
      n_before  = n_out;
      send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      wait_ov();
      repeat (3) @(negedge clk);
      check_val("bp_hold_rd", rd, 32'h40400000);
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain();
      check_val("bp_one_xfer", 32'(n_out - n_before), 32'd1);

      // Back-to-back: second pair accepted on the edge the first result leaves
      rise_q.delete();
      send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      send(32'h41200000, 32'h40A00000, 32'h40000000, 1'b0);
      drain();
      check_val("b2b_rises", 32'(rise_q.size()), 32'd2);
      if (rise_q.size() == 2)
         check_val("b2b_gap", 32'(rise_q[1] - rise_q[0]), 32'(LATENCY + 1));

      // Flush during WAIT with a new pair already offered
      n_before   = n_out;
      rs1        = 32'h40C00000;
      rs2        = 32'h40000000;
      exp_rd_cur = 32'h40400000;
      exp_dz_cur = 1'b0;
      in_valid   = 1'b1;
      @(negedge clk);
      check_val("fl_first_rdy", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #2;
      rs1        = 32'h41200000;
      rs2        = 32'h40A00000;
      exp_rd_cur = 32'h40000000;
      @(posedge clk);
      #2 flush = 1'b1;
      @(negedge clk);
      check_val("fl_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check_val("fl_busy", {31'b0, busy}, 32'd0);
      check_val("fl_out_valid", {31'b0, out_valid}, 32'd0);
      sb_q.delete();
      flush = 1'b0;
      #1;
      check_val("fl_in_ready_after", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #2 in_valid = 1'b0;
      drain();
      check_val("fl_one_xfer", 32'(n_out - n_before), 32'd1);

      // Asynchronous reset while a result is held
      out_ready = 1'b0;
      send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      wait_ov();
      @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      check_val("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check_val("arst_rd", rd, 32'd0);
      check_val("arst_busy", {31'b0, busy}, 32'd0);
      check_val("arst_in_ready", {31'b0, in_ready}, 32'd0);
      sb_q.delete();
      n_before = n_out;
      repeat (3) @(posedge clk);
      #2;
      rstn      = 1'b1;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      check_val("arst_no_stale", 32'(n_out - n_before), 32'd0);
      check_val("arst_idle_ov", {31'b0, out_valid}, 32'd0);

      // Operation after reset still correct
      @(posedge clk);
      #2;
      send(32'h41200000, 32'h40A00000, 32'h40000000, 1'b0);
      drain();
      check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fdiv_mc.md
FDIV_MC -- requirements
Module: fdiv_mc

Interface
REQ-001 Parameter LATENCY, default 4, meaning settle cycles granted to the combinational fdiv path; legal range 1..15.
REQ-002 clk  input  1  meaning system clock, all state on rising edge.
REQ-003 rstn  input  1  meaning reset, asynchronous and active-low.
REQ-004 in_valid  input  1  meaning operand pair offered.
REQ-005 in_ready  output  1  meaning block accepts operands this cycle.
REQ-006 rs1  input  32  meaning dividend, IEEE-754 single.
REQ-007 rs2  input  32  meaning divisor, IEEE-754 single.
REQ-008 flush  input  1  meaning synchronous abort of any in-flight or held result.
REQ-009 out_valid  output  1  meaning rd/dz hold a result.
REQ-010 out_ready  input  1  meaning consumer takes the result this cycle.
REQ-011 rd  output  32  meaning quotient, registered.
REQ-012 dz  output  1  meaning divide-by-zero flag, qualified by out_valid.
REQ-013 busy  output  1  meaning state is not IDLE.

Function
REQ-014 States IDLE, WAIT, DONE; 4-bit down-counter cnt.
REQ-015 Accept = in_valid && in_ready at a rising edge; rs1/rs2 latched into operand registers, cnt loaded LATENCY-1, state -> WAIT.
REQ-016 in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
REQ-017 Operand registers drive the fdiv instance and remain stable from the accept edge until the next accept edge.
REQ-018 WAIT: cnt decrements each edge; on the edge where cnt==0, rd/dz registers capture, state -> DONE.
REQ-019 Latency: out_valid rises exactly LATENCY edges after the accept edge (LATENCY=4 -> 4th edge).
REQ-020 DONE: rd, dz, out_valid held constant while out_ready==0.
REQ-021 DONE && out_ready: accept with in_valid -> WAIT (back-to-back, zero bubble); without in_valid -> IDLE, out_valid 0.
REQ-022 Special cases, sign = rs1[31]^rs2[31]: rs2 exponent==0 and rs1 exponent!=0 -> rd={sign,8'hFF,23'h0}, dz=1; both exponents 0 -> rd={sign,31'h0}, dz=1; otherwise rd=fdiv result, dz=0.
REQ-023 Special-case decode uses the latched operands, not live inputs.
REQ-024 flush high at an edge: state -> IDLE, out_valid 0, cnt 0, no accept that cycle; flush overrides any simultaneous handshake.
REQ-025 in_valid in WAIT is ignored (in_ready 0); operands are not consumed.

Reset
REQ-026 rstn low asynchronously forces state IDLE, cnt 0, operand registers 0, rd 0, dz 0, out_valid 0.
REQ-027 in_ready is 0 while rstn is low and 1 on the first cycle after release.
REQ-028 Reset mid-WAIT or mid-DONE discards the operation; no result emitted after release.

Structure
REQ-029 Shared package fpu_pkg holds state encoding enum, EXP_ZERO=8'h00, EXP_INF=8'hFF, BIAS=8'h7F, and the 32-bit float width constant.
REQ-030 Exactly one sub-module: the existing combinational fdiv, instantiated once; timing declares fdiv paths multicycle = LATENCY.
REQ-031 Control, counter and special-case logic are in fdiv_mc itself; target 120-250 RTL lines.

Verification
REQ-032 6.0/2.0: rs1=0x40C00000, rs2=0x40000000 accepted at edge 0 -> out_valid at edge 4, rd=0x40400000, dz=0.
REQ-033 Divide by zero: rs1=0x3F800000, rs2=0x80000000 -> rd=0xFF800000, dz=1; rs1=0, rs2=0 -> rd=0x00000000, dz=1.
REQ-034 Backpressure: out_ready low 3 cycles after out_valid -> rd/dz unchanged, in_ready 0, one transfer on release.
REQ-035 Back-to-back: second pair (0x41200000/0x40A00000) offered with out_ready=1 in DONE -> accepted same edge, 2nd rd=0x40000000 exactly 4 edges later.
REQ-036 flush at edge 2 of WAIT with in_valid=1 -> IDLE, no out_valid, in_ready 1 next cycle, next op correct.
REQ-037 rstn pulsed low mid-DONE -> out_valid drops immediately (asynchronous), no stale result after release.
